writeback_unit: RTL and testbench
=================================

# writeback_unit

Write-side initiator for the core's register file: collects results from the single-cycle ALU path and the multi-cycle load/MDU path over valid/ready handshakes, buffers them in a small FIFO, and drives the register file's single write port at most once per cycle. It optionally keeps a per-register busy scoreboard so the decode stage can stall on RAW/WAW hazards against in-flight results.

## Interface
- DEPTH, default 4: FIFO entries, power of two, 2..16.
- clk  input  1  core clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted this cycle when alu_valid is high.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- mem_valid, mem_ready, mem_rd, mem_data: same as the alu_* ports, for the load/MDU path.
- issue_valid  input  1  decode issues an instruction that writes issue_rd.
- issue_rd  input  5  destination of the issued instruction.
- chk_rs1, chk_rs2, chk_rd  input  5 each  decode-stage hazard query.
- hazard  output  1  any queried register is busy (combinational).
- regWrite  output  1  write strobe to the register file.
- writeRegister  output  5  write address.
- writeData  output  32  write data.

## Operation
- FIFO of {rd, data}, DEPTH entries, read/write pointers one bit wider than the index; full when the MSBs differ and the index bits are equal, empty when the pointers are equal.
- Enqueue: at most one entry per cycle. mem_* has fixed priority over alu_*.
- mem_ready = !full. alu_ready = !full && !mem_valid.
- Both ready outputs are 0 while reset is asserted.
- Dequeue: whenever the FIFO is not empty, the head is popped and registered onto the write port.
  - regWrite is 1 only if the head's rd != 0. An entry with rd == 0 is consumed silently; regWrite stays 0 and the data is discarded.
- Full FIFO with a simultaneous pop: ready stays 0 that cycle (full is evaluated on current state, not look-ahead).
- Pointers wrap modulo 2*DEPTH. No entry is lost or duplicated at the wrap point.
- Scoreboard (see Configuration): busy[31:1], where busy[0] is hard-wired 0.
  - issue_valid && issue_rd != 0 sets busy[issue_rd].
  - A pop with rd != 0 clears busy[rd].
  - If set and clear target the same register in the same cycle, set wins.
- hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]. Including chk_rd lets decode stall on WAW, so at most one write per rd is in flight and a single busy bit per register is sufficient.

## Timing
- Reset values:
  - regWrite = 0, writeRegister = 0, writeData = 0.
  - FIFO empty; all busy bits 0; hazard = 0.
  - alu_ready = mem_ready = 0 while reset is asserted, 1 from the first cycle after release.
- Latency: a handshake accepted at edge N, into an empty FIFO, appears on regWrite/writeRegister/writeData after edge N+1. The register file commits it at edge N+2.
- Each queued entry adds one cycle. Sustained throughput is one write per cycle.
- regWrite is a single-cycle pulse per entry. Back-to-back entries produce consecutive pulses.
- Reset asserted mid-operation clears the FIFO, the scoreboard and the write port asynchronously. Pending results are dropped; no partial write is emitted.

## Configuration
- WB_SCOREBOARD_EN defined: the busy register, the set/clear logic and the hazard output are compiled in as described above.
- WB_SCOREBOARD_EN undefined: no busy storage. hazard is tied to 0, and issue_valid, issue_rd and chk_* are ignored. Decode must then rely on in-order single-issue timing for correctness.

## Structure
- Shared core package:
  - REG_ADDR_W = 5, XLEN = 32.
  - A wb_entry_t typedef {rd, data}, so the pipeline stages and this block agree on the layout.
- One natural sub-module: wb_fifo, a synchronous FIFO parameterised on DEPTH and the entry width, with full/empty flags and async active-low reset.
- Arbitration, the write-port register and the scoreboard live in writeback_unit.

## Test plan
- ALU single write:
  - Stimulus: alu_valid with rd=5, data=0xDEADBEEF into an idle unit.
  - Required: regWrite=1, writeRegister=5, writeData=0xDEADBEEF exactly one cycle after acceptance, then regWrite=0.
- Priority:
  - Stimulus: alu (rd=1, 0x11) and mem (rd=2, 0x22) valid in the same cycle.
  - Required: mem accepted first (alu_ready=0), alu accepted the next cycle; writes appear in order rd=2 then rd=1.
- Full and wrap:
  - Stimulus: DEPTH=4, hold alu_valid for 10 cycles with rd=1..10, data=rd.
  - Required: alu_ready drops only when the FIFO is full; all 10 writes appear in order with no loss across the pointer wrap.
- x0 drop:
  - Stimulus: mem_rd=0, data=0xFFFFFFFF.
  - Required: entry accepted, regWrite stays 0, FIFO returns to empty.
- Scoreboard (WB_SCOREBOARD_EN defined):
  - Stimulus: issue rd=7, then query chk_rs1=7; later, a pop of rd=7 in the same cycle as a new issue of rd=7.
  - Required: hazard=1 until the cycle after the write of rd=7 pops. On the simultaneous pop and issue, busy[7] remains 1.
- Reset mid-stream:
  - Stimulus: three entries queued, then reset asserted low.
  - Required: regWrite=0 immediately; after release, no stale writes appear, busy is all 0, and ready returns to 1.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg
// Shared core definitions for the write-back path: register-file address and
// data widths, and the {rd, data} entry layout used by the pipeline stages
// and by writeback_unit's result FIFO.
package writeback_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if
// Bundles the result handshakes (ALU and load/MDU paths), the decode-stage
// issue/hazard query and the register-file write port.
//   master : writeback_unit side (accepts results, drives the write port,
//            answers hazard queries)
//   slave  : surrounding pipeline / register file side
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] chk_rs1;
    logic [REG_ADDR_W-1:0] chk_rs2;
    logic [REG_ADDR_W-1:0] chk_rd;
    logic                  hazard;

    logic                  regWrite;
    logic [REG_ADDR_W-1:0] writeRegister;
    logic [XLEN-1:0]       writeData;

    modport master (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
        output hazard,
        output regWrite, writeRegister, writeData
    );

    modport slave (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd,
        input  hazard,
        input  regWrite, writeRegister, writeData
    );

endinterface

// File: rtl/writeback_unit_fifo.sv
// wb_fifo
// Synchronous FIFO, DEPTH entries (power of two) of WIDTH bits.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_data       write request / data (ignored when full)
//   pop, pop_data         read request (ignored when empty) / head entry
//   full, empty           status of the current state
// Pointers are one bit wider than the index: equal pointers mean empty,
// differing MSBs with equal index bits mean full.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] store [DEPTH];

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_data = store[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (push && !full) store[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit
// Collects results from the ALU and load/MDU paths, queues them in a FIFO
// and drives the register file's single write port at most once per cycle.
// Ports:
//   clk    core clock
//   reset  asynchronous active-low reset
//   wb     writeback_unit_if.master: alu_*/mem_* handshakes, issue/chk hazard
//          query, regWrite/writeRegister/writeData write port
// Parameter: DEPTH (power of two, 2..16) FIFO entries.
// Build option: define WB_SCOREBOARD_EN to include the per-register busy
// scoreboard and the hazard output; otherwise hazard is tied to 0.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    writeback_unit_if.master wb
);

    logic      full;
    logic      empty;
    logic      mem_take;
    logic      alu_take;
    logic      push;
    logic      pop;
    wb_entry_t in_entry;
    wb_entry_t head;

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [XLEN-1:0]       wr_data;

    // Readies are gated by reset so they read 0 while reset is held.
    assign wb.mem_ready = reset && !full;
    assign wb.alu_ready = reset && !full && !wb.mem_valid;

    assign mem_take = wb.mem_valid && reset && !full;
    assign alu_take = wb.alu_valid && reset && !full && !wb.mem_valid;
    assign push     = mem_take || alu_take;
    assign pop      = !empty;

    always_comb begin
        in_entry = '0;
        if (wb.mem_valid) begin
            in_entry.rd   = wb.mem_rd;
            in_entry.data = wb.mem_data;
        end else begin
            in_entry.rd   = wb.alu_rd;
            in_entry.data = wb.alu_data;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WB_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // Head is popped every non-empty cycle; x0 entries are consumed without
    // a strobe and leave the address/data registers untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pop && (head.rd != '0);
            if (pop && (head.rd != '0)) begin
                wr_reg  <= head.rd;
                wr_data <= head.data;
            end
        end
    end

    assign wb.regWrite      = wr_en;
    assign wb.writeRegister = wr_reg;
    assign wb.writeData     = wr_data;

`ifdef WB_SCOREBOARD_EN
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (wb.issue_valid) set_mask[wb.issue_rd] = 1'b1;
        if (pop)            clr_mask[head.rd]     = 1'b1;
    end

    // Set is applied after clear so a same-cycle issue keeps the bit busy;
    // bit 0 is masked so x0 never reports busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else        busy <= ((busy & ~clr_mask) | set_mask) & ~NREGS'(1);
    end

    assign wb.hazard = busy[wb.chk_rs1] | busy[wb.chk_rs2] | busy[wb.chk_rd];
`else
    logic unused_sb;
    assign unused_sb = ^{wb.issue_valid, wb.issue_rd, wb.chk_rs1, wb.chk_rs2, wb.chk_rd};
    assign wb.hazard = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
// Directed and random stimulus for writeback_unit, compared against a
// queue-based reference model of the result FIFO, write port and scoreboard.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    writeback_unit_if bus();

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    wb_entry_t q[$];
    logic      busy_m [NREGS];
    logic      exp_rw;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
    logic      last_alu_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
    endtask

    task automatic model_reset();
        q.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        exp_rw = 1'b0;
        exp_wr = '0;
        exp_wd = '0;
    endtask

    function automatic logic model_hazard();
`ifdef WB_SCOREBOARD_EN
        return busy_m[bus.chk_rs1] | busy_m[bus.chk_rs2] | busy_m[bus.chk_rd];
`else
        return 1'b0;
`endif
    endfunction

    // Called at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic step();
        logic      full_m, er_mem, er_alu;
        wb_entry_t e;
        #1;
        full_m = (q.size() == DEPTH);
        er_mem = !full_m;
        er_alu = !full_m && !bus.mem_valid;
        check("mem_ready", 32'(bus.mem_ready), 32'(er_mem));
        check("alu_ready", 32'(bus.alu_ready), 32'(er_alu));
        check("hazard", 32'(bus.hazard), 32'(model_hazard()));

        exp_rw = 1'b0;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.rd != 0) begin
                exp_rw = 1'b1;
                exp_wr = e.rd;
                exp_wd = e.data;
                busy_m[e.rd] = 1'b0;
            end
        end
`ifdef WB_SCOREBOARD_EN
        if (bus.issue_valid && bus.issue_rd != 0) busy_m[bus.issue_rd] = 1'b1;
`endif
        last_alu_acc = 1'b0;
        if (bus.mem_valid && er_mem) begin
            e.rd = bus.mem_rd; e.data = bus.mem_data; q.push_back(e);
        end else if (bus.alu_valid && er_alu) begin
            e.rd = bus.alu_rd; e.data = bus.alu_data; q.push_back(e);
            last_alu_acc = 1'b1;
        end

        @(posedge clk);
        #1;
        check("regWrite", 32'(bus.regWrite), 32'(exp_rw));
        check("writeRegister", 32'(bus.writeRegister), 32'(exp_wr));
        check("writeData", bus.writeData, exp_wd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_regWrite"}, 32'(bus.regWrite), 32'd0);
        check({tag, "_writeRegister"}, 32'(bus.writeRegister), 32'd0);
        check({tag, "_writeData"}, bus.writeData, 32'd0);
        check({tag, "_alu_ready"}, 32'(bus.alu_ready), 32'd0);
        check({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'd0);
        check({tag, "_hazard"}, 32'(bus.hazard), 32'd0);
    endtask

    initial begin
        int unsigned nxt;
        idle_inputs();
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();

        // ALU single write
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        step();
        bus.alu_valid = 1'b0;
        step();
        check("alu_single_regWrite", 32'(bus.regWrite), 32'd1);
        check("alu_single_data", bus.writeData, 32'hDEADBEEF);
        step();

        // Priority: mem wins, alu follows next cycle
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'h22;
        step();
        bus.mem_valid = 1'b0;
        step();
        bus.alu_valid = 1'b0;
        repeat (3) step();

        // Sustained stream rd=1..10 across the pointer wrap
        nxt = 1;
        for (int i = 0; i < 40 && nxt <= 10; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(nxt);
            bus.alu_data  = 32'(nxt);
            step();
            if (last_alu_acc) nxt++;
        end
        idle_inputs();
        repeat (3) step();

        // x0 entry is consumed silently
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hFFFFFFFF;
        step();
        bus.mem_valid = 1'b0;
        step();
        check("x0_regWrite", 32'(bus.regWrite), 32'd0);
        step();

        // Scoreboard: issue rd7, write rd7 popping alongside a new issue of rd7
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.chk_rs1 = 5'd7;
        step();
        bus.issue_valid = 1'b0;
        repeat (2) step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        step();
        bus.alu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        step();
        bus.issue_valid = 1'b0;
        repeat (2) step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h78;
        step();
        bus.alu_valid = 1'b0;
        repeat (2) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.alu_valid   = 1'($urandom_range(0, 1));
            bus.alu_rd      = 5'($urandom);
            bus.alu_data    = $urandom;
            bus.mem_valid   = 1'($urandom_range(0, 1));
            bus.mem_rd      = 5'($urandom);
            bus.mem_data    = $urandom;
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_rd    = 5'($urandom);
            bus.chk_rs1     = 5'($urandom);
            bus.chk_rs2     = 5'($urandom);
            bus.chk_rd      = 5'($urandom);
            step();
        end

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(9 + i); bus.mem_data = 32'hA0 + 32'(i);
            bus.issue_valid = 1'b1; bus.issue_rd = 5'(20 + i);
            step();
        end
        bus.chk_rs1 = 5'd20; bus.chk_rs2 = 5'd21; bus.chk_rd = 5'd9;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) begin
            bus.chk_rs1 = 5'(r);
            bus.chk_rs2 = 5'(31 - r);
            bus.chk_rd  = 5'(r);
            step();
        end
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
